// File: rtl/core_outport_uart_tx.sv
// Purpose: buffers bytes from the core output-port strobe and serializes them as 8N1/8N2 UART frames.
// Latency: a write into an empty FIFO while idle drives the start bit two edges after the write edge.
// Backpressure: o_fifo_full tells the core to hold off; a write while full is dropped and flagged in sticky o_overflow.
module core_outport_uart_tx #(
  parameter int CLOCKS_PER_BIT = 868,
  parameter int FIFO_DEPTH     = 16,
  parameter int NSTOP          = 1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_outport_data,
  input  logic       i_outport_wr,
  input  logic       i_overflow_clr,
  output logic       o_fifo_full,
  output logic       o_busy,
  output logic       o_overflow,
  output logic       o_uart_tx
);

  localparam int BW = $clog2(CLOCKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLOCKS_PER_BIT - 1);
  localparam logic [AW:0]   DEPTH_C   = (AW+1)'(FIFO_DEPTH);
  localparam logic [2:0]    STOP_LAST = 3'(NSTOP - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t        state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          busy_q;
  logic          ovf_q;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;

  logic fifo_full, fifo_empty, wr_en, pop, baud_last;

  // Full is judged on the occupancy registered at the start of the cycle, so a
  // pop in the same cycle never rescues a write that arrives while full.
  assign fifo_full  = (count_q == DEPTH_C);
  assign fifo_empty = (count_q == '0);
  assign wr_en      = i_outport_wr && !fifo_full;
  assign baud_last  = (baud_q == BAUD_LAST);

  // Next-state, shift register and line level for the frame sequencer.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = 1'b1;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        baud_d = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          bit_d   = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        tx_d = 1'b0;
        if (baud_last) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        tx_d = shift_q[0];
        if (baud_last) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            bit_d   = '0;
            state_d = S_STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      S_STOP: begin
        tx_d = 1'b1;
        if (baud_last) begin
          baud_d = '0;
          if (bit_q == STOP_LAST) begin
            bit_d = '0;
            // Chain straight into the next start bit when more bytes wait.
            if (!fifo_empty) begin
              pop     = 1'b1;
              shift_d = mem_q[rd_ptr_q];
              state_d = S_START;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Sequencer, FIFO bookkeeping and status registers, all cleared by reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      ovf_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= !fifo_empty || (state_q != S_IDLE);
      if (i_outport_wr && fifo_full) ovf_q <= 1'b1;
      else if (i_overflow_clr)       ovf_q <= 1'b0;
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({wr_en, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Byte storage; no reset needed since occupancy guards every read.
  always_ff @(posedge i_clk) begin
    if (i_rst && wr_en) mem_q[wr_ptr_q] <= i_outport_data;
  end

  assign o_fifo_full = fifo_full;
  assign o_busy      = busy_q;
  assign o_overflow  = ovf_q;
  assign o_uart_tx   = tx_q;

endmodule

// File: tb/tb_core_outport_uart_tx.sv
// Directed bench for core_outport_uart_tx with CLOCKS_PER_BIT=4 and FIFO_DEPTH=4.
// Instance u_dut1 uses one stop bit, u_dut2 two stop bits; both see the same inputs.
// The serial line is sampled at every falling edge into logs and compared to a frame model.
module tb_core_outport_uart_tx;

  logic       clk = 1'b0;
  logic       rst, wr, clr;
  logic [7:0] data;
  logic       full1, busy1, ovf1, tx1;
  logic       full2, busy2, ovf2, tx2;

  int   n_assert = 0;
  int   n_fail   = 0;
  logic q1[$];
  logic q2[$];
  bit   logging  = 1'b0;
  int   lows;

  always #5 clk = ~clk;

  core_outport_uart_tx #(.CLOCKS_PER_BIT(4), .FIFO_DEPTH(4), .NSTOP(1)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_outport_data(data), .i_outport_wr(wr),
    .i_overflow_clr(clr), .o_fifo_full(full1), .o_busy(busy1),
    .o_overflow(ovf1), .o_uart_tx(tx1));

  core_outport_uart_tx #(.CLOCKS_PER_BIT(4), .FIFO_DEPTH(4), .NSTOP(2)) u_dut2 (
    .i_clk(clk), .i_rst(rst), .i_outport_data(data), .i_outport_wr(wr),
    .i_overflow_clr(clr), .o_fifo_full(full2), .o_busy(busy2),
    .o_overflow(ovf2), .o_uart_tx(tx2));

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: from a falling edge through the rising edge to the next falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    if (logging) begin
      q1.push_back(tx1);
      q2.push_back(tx2);
    end
  endtask

  task automatic write(input logic [7:0] d);
    data = d;
    wr   = 1'b1;
    step();
    wr   = 1'b0;
  endtask

  // Expected line level k samples into a frame with 4 clocks per bit.
  function automatic logic exp_bit(input logic [7:0] b, input int k);
    int j;
    j = k / 4;
    if (j == 0) return 1'b0;
    else if (j <= 8) return b[j-1];
    else return 1'b1;
  endfunction

  task automatic chk_frame(input string tag, input bit second, input int base,
                           input logic [7:0] b, input int len);
    for (int k = 0; k < len; k++)
      chk($sformatf("%s s%0d", tag, k), second ? q2[base+k] : q1[base+k], exp_bit(b, k));
  endtask

  initial begin
    rst = 1'b0; wr = 1'b0; clr = 1'b0; data = 8'h00;
    @(negedge clk);
    step();
    step();
    chk("rst tx1", tx1, 1'b1);
    chk("rst full1", full1, 1'b0);
    chk("rst busy1", busy1, 1'b0);
    chk("rst ovf1", ovf1, 1'b0);
    chk("rst tx2", tx2, 1'b1);
    chk("rst full2", full2, 1'b0);
    chk("rst ovf2", ovf2, 1'b0);
    rst = 1'b1;
    step();

    // Single frame 0x55 with latency and busy timing.
    write(8'h55);
    chk("lat busy@N", busy1, 1'b0);
    step();
    chk("lat busy@N+1", busy1, 1'b1);
    chk("lat tx@N+1", tx1, 1'b1);
    q1.delete(); q2.delete(); logging = 1'b1;
    repeat (40) step();
    chk("f55 busy@N+41", busy1, 1'b1);
    step();
    chk("f55 busy@N+42", busy1, 1'b0);
    chk("f55 tx idle", tx1, 1'b1);
    chk_frame("f55", 1'b0, 0, 8'h55, 40);
    logging = 1'b0;

    // Back-to-back frames 0xA3 then 0x0F.
    repeat (10) step();
    write(8'hA3);
    write(8'h0F);
    q1.delete(); q2.delete(); logging = 1'b1;
    repeat (80) step();
    chk("b2b busy@N+81", busy1, 1'b1);
    step();
    chk("b2b busy@N+82", busy1, 1'b0);
    chk_frame("fA3", 1'b0, 0, 8'hA3, 40);
    chk_frame("f0F", 1'b0, 40, 8'h0F, 40);
    logging = 1'b0;

    // Fill past capacity, overflow set/clear, set-wins-over-clear.
    repeat (20) step();
    write(8'h11);
    write(8'h22);
    q1.delete(); q2.delete(); logging = 1'b1;
    write(8'h33);
    write(8'h44);
    chk("ovf full after 4th", full1, 1'b0);
    write(8'h55);
    chk("ovf full after 5th", full1, 1'b1);
    chk("ovf flag after 5th", ovf1, 1'b0);
    write(8'h66);
    chk("ovf flag after 6th", ovf1, 1'b1);
    chk("ovf full after 6th", full1, 1'b1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("ovf cleared", ovf1, 1'b0);
    data = 8'h77; wr = 1'b1; clr = 1'b1;
    step();
    wr = 1'b0; clr = 1'b0;
    chk("ovf set wins", ovf1, 1'b1);
    chk("ovf still full", full1, 1'b1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("ovf cleared again", ovf1, 1'b0);
    while (q1.size() < 220) step();
    chk_frame("o11", 1'b0, 0,   8'h11, 40);
    chk_frame("o22", 1'b0, 40,  8'h22, 40);
    chk_frame("o33", 1'b0, 80,  8'h33, 40);
    chk_frame("o44", 1'b0, 120, 8'h44, 40);
    chk_frame("o55", 1'b0, 160, 8'h55, 40);
    lows = 0;
    for (int k = 200; k < 220; k++) if (q1[k] !== 1'b1) lows++;
    chk("ovf no 6th frame", 8'(lows), 8'd0);
    chk("ovf busy end", busy1, 1'b0);
    logging = 1'b0;

    // Reset in the middle of the data bits of 0x00 with two bytes queued.
    write(8'h00);
    write(8'hAA);
    write(8'hBB);
    repeat (8) step();
    chk("mid pre-reset tx", tx1, 1'b0);
    chk("mid pre-reset full", full1, 1'b0);
    chk("mid pre-reset busy", busy1, 1'b1);
    rst = 1'b0;
    step();
    chk("mid rst tx", tx1, 1'b1);
    chk("mid rst busy", busy1, 1'b0);
    chk("mid rst full", full1, 1'b0);
    chk("mid rst ovf", ovf1, 1'b0);
    chk("mid rst tx2", tx2, 1'b1);
    rst = 1'b1;
    q1.delete(); q2.delete(); logging = 1'b1;
    repeat (60) step();
    lows = 0;
    for (int k = 0; k < 60; k++) if (q1[k] !== 1'b1) lows++;
    chk("mid no frames", 8'(lows), 8'd0);
    chk("mid busy idle", busy1, 1'b0);
    logging = 1'b0;

    // Two stop bits: 0xFF frame of 44 clocks.
    write(8'hFF);
    step();
    q1.delete(); q2.delete(); logging = 1'b1;
    repeat (44) step();
    chk_frame("s2 FF", 1'b1, 0, 8'hFF, 44);
    chk("s2 busy@N+45", busy2, 1'b1);
    chk("s1 busy@N+45", busy1, 1'b0);
    step();
    chk("s2 busy@N+46", busy2, 1'b0);
    chk("s2 tx idle", tx2, 1'b1);
    logging = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
